// File: rtl/dmem_responder.sv
// Data-memory target for the core's dmem port: byte-lane RAM with one-cycle load latency,
// plus a 16-byte MMIO page holding LEDs, a 64-bit cycle counter and a scratch word.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_we,
  input  logic [3:0]  dmem_be,
  input  logic [2:0]  dmem_funct3,
  output logic [31:0] dmem_rdata,
  output logic [3:0]  leds_out,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_MMIO = 2'd1,
    SRC_ZERO = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    REG_LED      = 2'd0,
    REG_CYCLE_LO = 2'd1,
    REG_CYCLE_HI = 2'd2,
    REG_SCRATCH  = 2'd3
  } mmio_reg_e;

  logic [31:0] mem [DEPTH_WORDS];

  // Request decode
  logic [31:0]   mmio_off;
  logic          is_mmio;
  logic          misaligned;
  logic          store_ok;
  logic          ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0]   wdata_placed;
  mmio_reg_e     mmio_reg;
  logic [31:0]   mmio_rd;

  // Architectural state
  logic [63:0] cycle_cnt;
  logic [31:0] hi_shadow;
  logic [31:0] scratch;

  // Read pipeline
  logic [31:0] rd_word_q;
  logic [31:0] mmio_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  src_e        src_q;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mmio_off   = dmem_addr - MMIO_BASE;
    is_mmio    = (mmio_off < 32'd16);
    mmio_reg   = mmio_reg_e'(mmio_off[3:2]);
    ram_idx    = dmem_addr[AW+1:2];
    misaligned = ((dmem_funct3[1:0] == 2'b01) && dmem_addr[0]) ||
                 ((dmem_funct3[1:0] == 2'b10) && (dmem_addr[1:0] != 2'b00));
    store_ok   = dmem_we && !misaligned;
    ram_we     = store_ok && !is_mmio && !rst;

    wdata_placed = dmem_wdata;
    case (dmem_funct3[1:0])
      2'b00:   wdata_placed = {24'b0, dmem_wdata[7:0]}  << {dmem_addr[1:0], 3'b000};
      2'b01:   wdata_placed = {16'b0, dmem_wdata[15:0]} << {dmem_addr[1], 4'b0000};
      default: wdata_placed = dmem_wdata;
    endcase

    mmio_rd = 32'b0;
    case (mmio_reg)
      REG_LED:      mmio_rd = {28'b0, leds_out};
      REG_CYCLE_LO: mmio_rd = cycle_cnt[31:0];
      REG_CYCLE_HI: mmio_rd = hi_shadow;
      REG_SCRATCH:  mmio_rd = scratch;
      default:      mmio_rd = 32'b0;
    endcase
  end

  // NOTE: the RAM array has no reset; only its write port is gated so a store racing rst is dropped.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_be[i]) mem[ram_idx][8*i +: 8] <= wdata_placed[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt    <= 64'b0;
      hi_shadow    <= 32'b0;
      scratch      <= 32'b0;
      leds_out     <= 4'b0;
      misalign_err <= 1'b0;
      rd_word_q    <= 32'b0;
      mmio_q       <= 32'b0;
      off_q        <= 2'b0;
      funct3_q     <= 3'b0;
      src_q        <= SRC_RAM;
    end else begin
      cycle_cnt    <= cycle_cnt + 64'd1;
      misalign_err <= misalign_err | misaligned;

      // Read-first: a store in this cycle is not visible to this cycle's load.
      rd_word_q <= mem[ram_idx];
      mmio_q    <= mmio_rd;
      off_q     <= dmem_addr[1:0];
      funct3_q  <= dmem_funct3;
      if (misaligned)   src_q <= SRC_ZERO;
      else if (is_mmio) src_q <= SRC_MMIO;
      else              src_q <= SRC_RAM;

      // Reading CYCLE_LO freezes the upper half so a following CYCLE_HI read is coherent.
      if (!dmem_we && !misaligned && is_mmio && (mmio_reg == REG_CYCLE_LO))
        hi_shadow <= cycle_cnt[63:32];

      if (store_ok && is_mmio) begin
        case (mmio_reg)
          REG_LED: if (dmem_be[0]) leds_out <= dmem_wdata[3:0];
          REG_SCRATCH: begin
            for (int i = 0; i < 4; i++) begin
              if (dmem_be[i]) scratch[8*i +: 8] <= wdata_placed[8*i +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Load formatting from the registered request
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ram_fmt;

  always_comb begin
    byte_sel = rd_word_q[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    ram_fmt  = rd_word_q;
    case (funct3_q)
      3'b000:  ram_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ram_fmt = {24'b0, byte_sel};
      3'b001:  ram_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  ram_fmt = {16'b0, half_sel};
      default: ram_fmt = rd_word_q;
    endcase

    case (src_q)
      SRC_MMIO: dmem_rdata = mmio_q;
      SRC_ZERO: dmem_rdata = 32'b0;
      default:  dmem_rdata = ram_fmt;
    endcase
  end

endmodule
